fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction prefetch buffer between the 16-bit instruction memory port and the IF/ID stage register. It fetches each 32-bit instruction as two consecutive half-word reads and stores up to DEPTH assembled {instr, pc} entries. Decode consumes entries through a valid/ready handshake. On an execute-stage jump it flushes and redirects, discarding any memory response still in flight.

## Interface
- DEPTH, 4: number of FIFO entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000: fetch address after reset.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- jump  in  1  redirect request from execute.
- target  in  32  redirect address; sampled when jump=1.
- mem_req  out  1  registered read request.
- mem_addr  out  32  registered half-word byte address; stable while mem_req=1.
- mem_ack  in  1  completes the request at an edge where mem_req=1.
- mem_rdata  in  16  read data; valid in the ack cycle.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  head instruction.
- out_pc  out  32  head instruction address.

## Operation
- State: fpc (next instruction address), hi (16-bit half latch), FIFO of {instr, pc}, count (0..DEPTH), and an FSM with states IDLE, REQ_HI, REQ_LO, WAIT, DISCARD.
- Transfer: a rising edge with mem_req=1 and mem_ack=1. Only one request is ever outstanding. mem_req never drops before its ack.
- IDLE: state while rst is low. The first edge after release moves to REQ_HI with mem_req=1 and mem_addr=fpc.
- REQ_HI: on transfer, hi<=mem_rdata and the FSM goes to REQ_LO with mem_addr=fpc+2.
- REQ_LO: on transfer, push {hi, mem_rdata} with pc=fpc, and set fpc<=fpc+4.
  - If the post-edge count is below DEPTH, go to REQ_HI at the new fpc.
  - Otherwise go to WAIT with mem_req=0.
- WAIT: stay while count=DEPTH. On the edge that pops an entry, go to REQ_HI.
- Pop: an edge with out_valid && out_ready. The next entry, if any, appears at the head the following cycle.
- Push and pop may share an edge; count stays the same. A push never occurs into a full FIFO, because each REQ_HI is issued only when a slot is free.
- Big-endian assembly: the half at fpc is out_instr[31:16]; the half at fpc+2 is out_instr[15:0].
- All address arithmetic is 32-bit modulo 2^32, wrapping at 32'hFFFF_FFFC+4 to 0.
- Jump has priority over push, pop and normal transitions. At the jump edge:
  - count<=0, the FIFO is emptied and hi is dropped.
  - fpc<=target.
  - If mem_req=1 and mem_ack=0, go to DISCARD. mem_req and mem_addr keep their old values.
  - Otherwise (no request, or acked on this edge), go to REQ_HI at target. Any acked data is dropped.
- DISCARD: wait for the ack and drop its data, then go to REQ_HI at fpc.
  - A second jump during DISCARD only updates fpc.
- A consumer handshake on the jump edge is ignored by the FIFO; decode is flushed by the pipeline controller.
- A reset mid-request clears all state immediately; any late ack is ignored.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, count=0, fpc=RESET_PC.
- Zero-wait memory (mem_ack tied to 1):
  - mem_req rises in cycle 1 after reset release.
  - The HI transfer occurs at the end of cycle 1 and the LO transfer at the end of cycle 2.
  - out_valid=1 from cycle 3.
  - Sustained throughput is one instruction per 2 cycles.
- With W wait cycles per read, each instruction takes 2(W+1) cycles.
- out_valid drops in the cycle after a jump edge. After a jump with zero-wait memory, the first redirected instruction is valid 3 cycles after the jump edge. DISCARD adds the remaining wait of the old request.
- mem_req, mem_addr, out_valid, out_instr and out_pc are all register outputs, with no combinational paths from inputs.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release -> all outputs at reset values during reset; mem_req=1 with mem_addr=0 on the first cycle after release.
- Streaming: zero-wait memory, mem[0]=16'h1234, mem[2]=16'h5678, out_ready=1 -> out_instr=32'h1234_5678 with out_pc=0 in cycle 3; the next instruction (pc=4) two cycles later.
- Backpressure: out_ready=0, DEPTH=4 -> four entries with pcs 0, 4, 8, 12; mem_req=0 in WAIT. Pulse out_ready for one cycle -> mem_req=1 on the next cycle with mem_addr=16.
- Jump during a wait-state read: ack delayed 3 cycles while mem_addr=6; jump with target=32'h100 -> out_valid=0 next cycle; mem_addr stays 6 until the ack; that data is dropped; the next request goes to 32'h100; out_pc=32'h100.
- Jump coinciding with an ack: jump=1 and mem_ack=1 on the same edge -> no push; the next cycle has mem_req=1 with mem_addr=target.
- Wrap-around: RESET_PC=32'hFFFF_FFFC -> the second instruction has out_pc=0 and mem_addr sequence FFFF_FFFC, FFFF_FFFE, 0, 2.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: two half-word reads per instruction,
// assembled into a small FIFO of {instr, pc} for the decode stage.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump,
  input  logic [31:0] target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    REQ_HI,
    REQ_LO,
    WAIT,
    DISCARD
  } state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [15:0]   hi;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_left;
  logic [CW-1:0] cnt_next;
  logic          xfer;
  logic          push;
  logic          pop;
  logic [31:0]   push_instr;
  logic [31:0]   head_instr;
  logic [31:0]   head_pc;

  // Head registers are loaded with the entry that will be at the
  // head after this edge, bypassing the array when it is empty.
  always_comb begin
    xfer       = mem_req & mem_ack;
    push       = xfer && (state == REQ_LO);
    pop        = out_valid & out_ready;
    push_instr = {hi, mem_rdata};
    rd_next    = rd_ptr + AW'(pop);
    cnt_left   = count - CW'(pop);
    cnt_next   = cnt_left + CW'(push);
    if (cnt_left == '0) begin
      head_instr = push_instr;
      head_pc    = fpc;
    end else begin
      head_instr = buf_instr[rd_next];
      head_pc    = buf_pc[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !jump) begin
      buf_instr[wr_ptr] <= push_instr;
      buf_pc[wr_ptr]    <= fpc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fpc       <= RESET_PC;
      hi        <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (jump) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      hi        <= '0;
      out_valid <= 1'b0;
      fpc       <= target;
      // An unacked request must still complete on the bus.
      if (mem_req && !mem_ack) begin
        state <= DISCARD;
      end else begin
        state    <= REQ_HI;
        mem_req  <= 1'b1;
        mem_addr <= target;
      end
    end else begin
      count     <= cnt_next;
      rd_ptr    <= rd_next;
      out_valid <= (cnt_next != '0);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (cnt_next != '0) begin
        out_instr <= head_instr;
        out_pc    <= head_pc;
      end
      unique case (state)
        IDLE: begin
          state    <= REQ_HI;
          mem_req  <= 1'b1;
          mem_addr <= fpc;
        end
        REQ_HI: begin
          if (xfer) begin
            hi       <= mem_rdata;
            state    <= REQ_LO;
            mem_addr <= fpc + 32'd2;
          end
        end
        REQ_LO: begin
          if (xfer) begin
            fpc <= fpc + 32'd4;
            if (cnt_next < FULL) begin
              state    <= REQ_HI;
              mem_addr <= fpc + 32'd4;
            end else begin
              state   <= WAIT;
              mem_req <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (pop) begin
            state    <= REQ_HI;
            mem_req  <= 1'b1;
            mem_addr <= fpc;
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            state    <= REQ_HI;
            mem_addr <= fpc;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: directed phases push expected
// entries, a monitor pops and compares on every decode handshake.
module tb_fetch_buffer;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump = 1'b0;
  logic [31:0] target = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        w_mem_req;
  logic [31:0] w_mem_addr;
  logic [15:0] w_rdata;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   slow_wait = 0;
  int   wcnt = 0;

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .jump(jump), .target(target),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .jump(1'b0), .target(32'h0),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_ack(1'b1), .mem_rdata(w_rdata),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .out_instr(w_out_instr), .out_pc(w_out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 16'h1234;
    if (a == 32'h2) return 16'h5678;
    return a[15:0] ^ 16'hA5A5;
  endfunction

  assign w_rdata = mem_f(w_mem_addr);

  // Memory model: address 6 optionally takes slow_wait wait cycles.
  always @(posedge clk) begin
    #1;
    if (!mem_req) begin
      wcnt    = 0;
      mem_ack = 1'b0;
    end else begin
      mem_ack   = (wcnt >= ((mem_addr == 32'h6) ? slow_wait : 0));
      mem_rdata = mem_f(mem_addr);
      wcnt      = mem_ack ? 0 : wcnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop pc=%h instr=%h", out_pc, out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_instr", out_instr, e.instr);
        chk("pop_pc", out_pc, e.pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = {mem_f(pc), mem_f(pc + 32'd2)};
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    jump = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_req", {31'b0, mem_req}, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_waddr", w_mem_addr, 32'hFFFF_FFFC);
    end
    rst = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 32'h0);
    out_ready = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // Streaming with zero-wait memory, plus the wrapping instance
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
    do_reset();
    tick();
    chk("c1_req", {31'b0, mem_req}, 32'h1);
    chk("c1_addr", mem_addr, 32'h0);
    chk("w_c1_req", {31'b0, w_mem_req}, 32'h1);
    chk("w_c1_addr", w_mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("c2_addr", mem_addr, 32'h2);
    chk("w_c2_addr", w_mem_addr, 32'hFFFF_FFFE);
    tick();
    chk("c3_valid", {31'b0, out_valid}, 32'h1);
    chk("c3_instr", out_instr, 32'h1234_5678);
    chk("c3_pc", out_pc, 32'h0);
    chk("w_c3_addr", w_mem_addr, 32'h0);
    chk("w_c3_valid", {31'b0, w_out_valid}, 32'h1);
    chk("w_c3_pc", w_out_pc, 32'hFFFF_FFFC);
    chk("w_c3_instr", w_out_instr, 32'h5A59_5A5B);
    tick();
    chk("w_c4_addr", w_mem_addr, 32'h2);
    tick();
    chk("c5_pc", out_pc, 32'h4);
    chk("c5_instr", out_instr, 32'hA5A1_A5A3);
    chk("w_c5_pc", w_out_pc, 32'h0);
    chk("w_c5_instr", w_out_instr, 32'h1234_5678);
    drain();

    // Backpressure: fill all four slots, then release one
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
    do_reset();
    for (int i = 0; i < 12; i++) tick();
    chk("bp_wait_req", {31'b0, mem_req}, 32'h0);
    chk("bp_valid", {31'b0, out_valid}, 32'h1);
    chk("bp_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_resume_req", {31'b0, mem_req}, 32'h1);
    chk("bp_resume_addr", mem_addr, 32'h10);
    chk("bp_next_pc", out_pc, 32'h4);
    out_ready = 1'b1;
    drain();

    // Jump while the read at address 6 is stalled
    slow_wait = 3;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    chk("js_addr", mem_addr, 32'h6);
    chk("js_valid", {31'b0, out_valid}, 32'h1);
    jump   = 1'b1;
    target = 32'h100;
    tick();
    jump = 1'b0;
    chk("js_flush", {31'b0, out_valid}, 32'h0);
    chk("js_hold_req", {31'b0, mem_req}, 32'h1);
    chk("js_hold_addr", mem_addr, 32'h6);
    tick();
    chk("js_hold_addr2", mem_addr, 32'h6);
    tick();
    chk("js_redir_req", {31'b0, mem_req}, 32'h1);
    chk("js_redir_addr", mem_addr, 32'h100);
    push_exp(32'h100);
    push_exp(32'h104);
    out_ready = 1'b1;
    drain();
    slow_wait = 0;

    // Jump on the same edge as the low-half ack
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    chk("ja_addr", mem_addr, 32'h6);
    jump   = 1'b1;
    target = 32'h200;
    tick();
    jump = 1'b0;
    chk("ja_req", {31'b0, mem_req}, 32'h1);
    chk("ja_addr_tgt", mem_addr, 32'h200);
    chk("ja_flush", {31'b0, out_valid}, 32'h0);
    push_exp(32'h200);
    out_ready = 1'b1;
    tick();
    tick();
    chk("ja_valid", {31'b0, out_valid}, 32'h1);
    chk("ja_pc", out_pc, 32'h200);
    chk("ja_instr", out_instr, 32'hA7A5_A7A7);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
